// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes, ALU codes,
// IR field positions, sequencer states and the per-state control word.
package mini_src_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;
    localparam int C_MSB  = 18;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST, CLS_NOP, CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_in;
        logic       mar_in;
        logic       inc_pc;
        logic       z_in;
        logic       zlow_out;
        logic       mdr_out;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       c_out;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic [4:0] alu;
    } ctrl_t;

    // Unlisted opcodes fall into the nop class so they fetch and retire harmlessly.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU;
            OP_ADDI:                       cls = CLS_ADDI;
            OP_LD:                         cls = CLS_LD;
            OP_ST:                         cls = CLS_ST;
            OP_HALT:                       cls = CLS_HALT;
            default:                       cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_unit_select_encode.sv
// Register select logic: picks Ra/Rb/Rc by Gra>Grb>Grc priority, decodes it to
// one-hot load/drive enables, and sign-extends the 19-bit constant field.
module select_encode
    import mini_src_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    output logic [15:0] R_in,
    output logic [15:0] R_out,
    output logic        r0_zero,
    output logic [31:0] c_sext
);

    logic [3:0]  sel;
    logic        any_sel;
    logic [15:0] onehot;
    logic        unused_op_bits;

    always_comb begin
        sel = 4'd0;
        if (Gra) begin
            sel = ir[RA_MSB:RA_LSB];
        end else if (Grb) begin
            sel = ir[RB_MSB:RB_LSB];
        end else if (Grc) begin
            sel = ir[RC_MSB:RC_LSB];
        end
    end

    // No select line means no register is addressed, so the decode stays empty.
    assign any_sel = Gra | Grb | Grc;
    assign onehot  = any_sel ? (16'h0001 << sel) : 16'h0000;

    assign R_in    = onehot & {16{Rin}};
    assign R_out   = onehot & {16{Rout | BAout}};
    assign r0_zero = BAout & any_sel & (sel == 4'd0);
    assign c_sext  = {{13{ir[C_MSB]}}, ir[C_MSB:0]};

    assign unused_op_bits = ^ir[OP_MSB:OP_LSB];

endmodule

// File: rtl/control_unit.sv
// Mini-SRC hardwired sequencer: T-state FSM stepping fetch and execute, with a
// Moore decode of state plus IR onto the datapath and memory controls.
module control_unit
    import mini_src_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    input  logic        stop,
    output logic [15:0] R_in,
    output logic [15:0] R_out,
    output logic        r0_zero,
    output logic [31:0] c_sext,
    output logic        PCout,
    output logic        PCin,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        Zhighout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic [4:0]  ALU_Control,
    output logic        run
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctl;
    ctrl_t      ctl_q;
    op_class_t  cls;
    logic [4:0] opcode;
    logic [31:0] c_raw;

    assign opcode = ir[OP_MSB:OP_LSB];
    assign cls    = classify(opcode);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Memory handshake: a memory state (T1, ld T6, st T7) holds its controls
    // steady and advances only on an edge where mem_ack=1; elsewhere mem_ack is ignored.
    always_comb begin
        ctl        = '0;
        next_state = state;
        case (state)
            T0: begin
                if (stop) begin
                    next_state = HALT;
                end else begin
                    ctl.pc_out = 1'b1;
                    ctl.mar_in = 1'b1;
                    ctl.inc_pc = 1'b1;
                    ctl.z_in   = 1'b1;
                    next_state = T1;
                end
            end
            T1: begin
                ctl.zlow_out = 1'b1;
                ctl.pc_in    = 1'b1;
                ctl.read     = 1'b1;
                ctl.mdr_in   = 1'b1;
                if (mem_ack) next_state = T2;
            end
            T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
                case (cls)
                    CLS_NOP:  next_state = T0;
                    CLS_HALT: next_state = HALT;
                    default:  next_state = T3;
                endcase
            end
            T3: begin
                ctl.grb  = 1'b1;
                ctl.y_in = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    ctl.ba_out = 1'b1;
                end else begin
                    ctl.r_out = 1'b1;
                end
                next_state = T4;
            end
            T4: begin
                ctl.z_in = 1'b1;
                if (cls == CLS_ALU) begin
                    ctl.grc   = 1'b1;
                    ctl.r_out = 1'b1;
                    ctl.alu   = opcode;
                end else begin
                    ctl.c_out = 1'b1;
                    ctl.alu   = ALU_ADD;
                end
                next_state = T5;
            end
            T5: begin
                ctl.zlow_out = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    ctl.mar_in = 1'b1;
                    next_state = T6;
                end else begin
                    ctl.gra    = 1'b1;
                    ctl.r_in   = 1'b1;
                    next_state = T0;
                end
            end
            T6: begin
                ctl.mdr_in = 1'b1;
                if (cls == CLS_LD) begin
                    ctl.read = 1'b1;
                    if (mem_ack) next_state = T7;
                end else if (cls == CLS_ST) begin
                    // Read stays low so MDR captures the bus driven by Ra.
                    ctl.gra    = 1'b1;
                    ctl.r_out  = 1'b1;
                    next_state = T7;
                end else begin
                    ctl.mdr_in = 1'b0;
                    next_state = T0;
                end
            end
            T7: begin
                if (cls == CLS_LD) begin
                    ctl.mdr_out = 1'b1;
                    ctl.gra     = 1'b1;
                    ctl.r_in    = 1'b1;
                    next_state  = T0;
                end else if (cls == CLS_ST) begin
                    ctl.write = 1'b1;
                    if (mem_ack) next_state = T0;
                end else begin
                    next_state = T0;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = T0;
            end
        endcase
    end

    // clear overrides everything combinationally; HALT already decodes to all zeros.
    assign ctl_q = clear ? '0 : ctl;

    select_encode u_select_encode (
        .ir      (ir),
        .Gra     (ctl_q.gra),
        .Grb     (ctl_q.grb),
        .Grc     (ctl_q.grc),
        .Rin     (ctl_q.r_in),
        .Rout    (ctl_q.r_out),
        .BAout   (ctl_q.ba_out),
        .R_in    (R_in),
        .R_out   (R_out),
        .r0_zero (r0_zero),
        .c_sext  (c_raw)
    );

    assign c_sext      = (clear || state == HALT) ? 32'h0 : c_raw;
    assign run         = !clear && (state != HALT);

    assign PCout       = ctl_q.pc_out;
    assign PCin        = ctl_q.pc_in;
    assign MARin       = ctl_q.mar_in;
    assign IncPC       = ctl_q.inc_pc;
    assign Zin         = ctl_q.z_in;
    assign Zlowout     = ctl_q.zlow_out;
    assign MDRout      = ctl_q.mdr_out;
    assign MDRin       = ctl_q.mdr_in;
    assign IRin        = ctl_q.ir_in;
    assign Yin         = ctl_q.y_in;
    assign Cout        = ctl_q.c_out;
    assign Read        = ctl_q.read;
    assign Write       = ctl_q.write;
    assign ALU_Control = ctl_q.alu;

    assign Zhighout    = 1'b0;
    assign HIin        = 1'b0;
    assign HIout       = 1'b0;
    assign LOin        = 1'b0;
    assign LOout       = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction micro-step model feeds an expected
// queue of full output vectors, one per cycle; a negedge monitor pops and compares.
module tb_control_unit;

    localparam int W = 89;

    localparam logic [12:0] C_PCOUT  = 13'h1000;
    localparam logic [12:0] C_PCIN   = 13'h0800;
    localparam logic [12:0] C_MARIN  = 13'h0400;
    localparam logic [12:0] C_INCPC  = 13'h0200;
    localparam logic [12:0] C_ZIN    = 13'h0100;
    localparam logic [12:0] C_ZLOW   = 13'h0080;
    localparam logic [12:0] C_MDROUT = 13'h0040;
    localparam logic [12:0] C_MDRIN  = 13'h0020;
    localparam logic [12:0] C_IRIN   = 13'h0010;
    localparam logic [12:0] C_YIN    = 13'h0008;
    localparam logic [12:0] C_COUT   = 13'h0004;
    localparam logic [12:0] C_READ   = 13'h0002;
    localparam logic [12:0] C_WRITE  = 13'h0001;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ack;
    logic        stop;
    logic [15:0] R_in, R_out;
    logic        r0_zero;
    logic [31:0] c_sext;
    logic        PCout, PCin, MARin, IncPC, Zin, Zlowout, MDRout, MDRin, IRin;
    logic        Yin, Cout, Read, Write, Zhighout, HIin, HIout, LOin, LOout;
    logic [4:0]  ALU_Control;
    logic        run;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;

    logic [W-1:0] st_exp[8];
    bit           st_mem[8];
    int           st_n;
    bit           st_halt;
    logic [31:0]  st_csx;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ack(mem_ack), .stop(stop),
        .R_in(R_in), .R_out(R_out), .r0_zero(r0_zero), .c_sext(c_sext),
        .PCout(PCout), .PCin(PCin), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .MDRout(MDRout), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Cout(Cout), .Read(Read), .Write(Write), .Zhighout(Zhighout), .HIin(HIin),
        .HIout(HIout), .LOin(LOin), .LOout(LOout), .ALU_Control(ALU_Control), .run(run)
    );

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack(input logic [15:0] rin, input logic [15:0] rout,
                                          input logic r0z, input logic [31:0] csx,
                                          input logic [12:0] ctl, input logic [4:0] alu,
                                          input logic rn);
        return {rin, rout, r0z, csx, ctl, 5'b00000, alu, rn};
    endfunction

    function automatic void add_step(input logic [W-1:0] v, input bit m);
        st_exp[st_n] = v;
        st_mem[st_n] = m;
        st_n++;
    endfunction

    // Micro-step table for one instruction, straight from the RTN of each opcode.
    function automatic void build(input logic [31:0] i);
        logic [4:0]  op;
        int          ra, rb, rc;
        logic [15:0] oh_a, oh_b, oh_c;
        logic [31:0] csx;
        op   = i[31:27];
        ra   = int'(i[26:23]);
        rb   = int'(i[22:19]);
        rc   = int'(i[18:15]);
        oh_a = 16'(1) << ra;
        oh_b = 16'(1) << rb;
        oh_c = 16'(1) << rc;
        csx  = i[18] ? (32'(i[18:0]) | 32'hFFF8_0000) : 32'(i[18:0]);
        st_csx  = csx;
        st_n    = 0;
        st_halt = 0;
        add_step(pack(0, 0, 0, csx, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 0, 1), 0);
        add_step(pack(0, 0, 0, csx, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 0, 1), 1);
        add_step(pack(0, 0, 0, csx, C_MDROUT | C_IRIN, 0, 1), 0);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                add_step(pack(0, oh_b, 0, csx, C_YIN, 0, 1), 0);
                add_step(pack(0, oh_c, 0, csx, C_ZIN, op, 1), 0);
                add_step(pack(oh_a, 0, 0, csx, C_ZLOW, 0, 1), 0);
            end
            5'b01100: begin
                add_step(pack(0, oh_b, 0, csx, C_YIN, 0, 1), 0);
                add_step(pack(0, 0, 0, csx, C_COUT | C_ZIN, 5'd3, 1), 0);
                add_step(pack(oh_a, 0, 0, csx, C_ZLOW, 0, 1), 0);
            end
            5'b00000, 5'b00010: begin
                add_step(pack(0, oh_b, rb == 0, csx, C_YIN, 0, 1), 0);
                add_step(pack(0, 0, 0, csx, C_COUT | C_ZIN, 5'd3, 1), 0);
                add_step(pack(0, 0, 0, csx, C_ZLOW | C_MARIN, 0, 1), 0);
                if (op == 5'b00000) begin
                    add_step(pack(0, 0, 0, csx, C_READ | C_MDRIN, 0, 1), 1);
                    add_step(pack(oh_a, 0, 0, csx, C_MDROUT, 0, 1), 0);
                end else begin
                    add_step(pack(0, oh_a, 0, csx, C_MDRIN, 0, 1), 0);
                    add_step(pack(0, 0, 0, csx, C_WRITE, 0, 1), 1);
                end
            end
            5'b11011: st_halt = 1;
            default: ;
        endcase
    endfunction

    // Driver: inputs change #1 after the edge and the expected view of that cycle is queued.
    task automatic cycle(input bit c, input bit ack, input bit stp, input logic [31:0] i,
                         input logic [W-1:0] e, input string tag);
        @(posedge clock);
        #1;
        clear   = c;
        mem_ack = ack;
        stop    = stp;
        ir      = i;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic halt_run(input logic [31:0] i, input int n);
        repeat (n) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i, '0, "halt");
        cycle(1, 0, 0, i, '0, "halt_clear");
    endtask

    task automatic run_instr(input logic [31:0] i, input int abort_at, input bit stp,
                             input int fw, input int mw, input int halt_cycles);
        int    w;
        string tag;
        build(i);
        for (int k = 0; k < st_n; k++) begin
            tag = $sformatf("op%02h_T%0d", i[31:27], k);
            if (k == abort_at) begin
                cycle(1, 1'($urandom_range(0, 1)), 0, i, '0, "clear_mid");
                return;
            end
            if (k == 0 && stp) begin
                cycle(0, 1'($urandom_range(0, 1)), 1, i, pack(0, 0, 0, st_csx, 0, 0, 1), "stop_t0");
                halt_run(i, halt_cycles);
                return;
            end
            if (st_mem[k]) begin
                w = (k == 1) ? fw : mw;
                if (w < 0) w = $urandom_range(0, 3);
                repeat (w) cycle(0, 0, 1'($urandom_range(0, 1)), i, st_exp[k], tag);
                cycle(0, 1, 1'($urandom_range(0, 1)), i, st_exp[k], tag);
            end else begin
                cycle(0, 1'($urandom_range(0, 1)), (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                      i, st_exp[k], tag);
            end
        end
        if (st_halt) halt_run(i, halt_cycles);
    endtask

    // Monitor: every cycle the DUT presents a full output vector
    always @(negedge clock) begin
        logic [W-1:0] act, e;
        string        t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            act = {R_in, R_out, r0_zero, c_sext, PCout, PCin, MARin, IncPC, Zin, Zlowout,
                   MDRout, MDRin, IRin, Yin, Cout, Read, Write, Zhighout, HIin, HIout,
                   LOin, LOout, ALU_Control, run};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", t, cyc, act, e);
            end
        end
    end

    initial begin
        logic [4:0]  ops[10];
        logic [4:0]  op;
        logic [31:0] i;
        ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                5'b00110, 5'b01100, 5'b11010, 5'b11011, 5'b10101};
        clear = 1'b1; mem_ack = 1'b0; stop = 1'b0; ir = 32'h0;

        cycle(1, 0, 0, 32'h0, '0, "reset");
        run_instr(32'h1989_0000, -1, 0, 0, 0, 0);   // add R3,R1,R2
        run_instr(32'h1989_0000, -1, 0, 3, 0, 0);   // fetch wait
        run_instr(32'h0200_0010, -1, 0, 0, 0, 0);   // ld R4,0x10(R0)
        run_instr(32'h0207_FFFF, -1, 0, 0, 0, 0);   // ld with C=-1
        run_instr(32'h1290_0004, -1, 0, 0, 2, 0);   // st R5,4(R2) with Write wait
        run_instr(32'hD000_0000, -1, 0, 0, 0, 0);   // nop
        run_instr(32'hD800_0000, -1, 0, 0, 0, 20);  // halt
        run_instr(32'h1989_0000, -1, 1, 0, 0, 5);   // stop in T0
        run_instr(32'h1989_0000, 4, 0, 0, 0, 0);    // clear during T4
        run_instr(32'h6311_0005, -1, 0, -1, -1, 0); // addi

        for (int n = 0; n < 250; n++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 5'b10101) op = 5'($urandom_range(0, 31));
            i = {op, 27'($urandom())};
            run_instr(i,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1,
                      $urandom_range(0, 29) == 0, -1, -1, int'($urandom_range(1, 5)));
        end

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
